// File: rtl/conf_multi_if.sv
// rtl/conf_multi_if.sv - AXI4-Lite slave bundle for conf_multi
interface conf_multi_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/conf_multi.sv
// rtl/conf_multi.sv - AXI4-Lite multi-channel config block with command launch and IRQ
module conf_multi #(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int          NCHAN     = 2,
  parameter int          NREG_LOG2 = 2,
  parameter logic [15:0] VERSION   = 16'h0002
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  conf_multi_if.slave                         s_axi,
  output logic [NCHAN-1:0]                    CONFIG_VALID,
  input  logic [NCHAN-1:0]                    CONFIG_READY,
  input  logic [NCHAN-1:0]                    CONFIG_DONE,
  output logic [NCHAN*(2**NREG_LOG2)*32-1:0]  CONFIG_DATA,
  output logic                                CONFIG_IRQ
);
  localparam int NREG = 2**NREG_LOG2;
  localparam int CW   = $clog2(NCHAN + 1);
  localparam int AL   = 2 + NREG_LOG2 + CW;
  localparam logic [CW-1:0] GLOBAL_CHAN = CW'(NCHAN);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {CH_IDLE, CH_PEND, CH_RUN} ch_state_t;

  w_state_t  w_state, w_next;
  r_state_t  r_state, r_next;
  ch_state_t ch_state [NCHAN];
  ch_state_t ch_next  [NCHAN];

  logic        aw_held, w_held;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [31:0] data_q [NCHAN][NREG];
  logic [31:0] cnt_q  [NCHAN];
  logic [NCHAN-1:0] pend_q, mask_q;
  logic        irq_q;

  logic [CW-1:0]        wr_chan, rd_chan;
  logic [NREG_LOG2-1:0] wr_reg, rd_reg;
  logic        commit, wr_global, wr_locked, wr_ok, rd_global, rd_ok;
  logic [31:0] wmask, wbits, rd_value;
  logic [NCHAN-1:0] busy, launch, pend_set, pend_clr;
  logic        unused_addr_bits;

  function automatic logic in_window(input logic [31:0] a);
    return (a[31:AL] == ADDR_BASE[31:AL]) && (a[AL-1:NREG_LOG2+2] <= GLOBAL_CHAN);
  endfunction

  assign wr_chan = aw_addr[AL-1:NREG_LOG2+2];
  assign wr_reg  = aw_addr[NREG_LOG2+1:2];
  assign rd_chan = s_axi.araddr[AL-1:NREG_LOG2+2];
  assign rd_reg  = s_axi.araddr[NREG_LOG2+1:2];
  assign unused_addr_bits = ^{aw_addr[1:0], s_axi.araddr[1:0]};

  assign s_axi.awready = (w_state == W_IDLE) && !aw_held;
  assign s_axi.wready  = (w_state == W_IDLE) && !w_held;
  assign s_axi.bvalid  = (w_state == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = (r_state == R_IDLE);
  assign s_axi.rvalid  = (r_state == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign CONFIG_IRQ    = irq_q;

  always_comb begin : chan_status
    busy         = '0;
    CONFIG_VALID = '0;
    for (int c = 0; c < NCHAN; c++) begin
      busy[c]         = (ch_state[c] != CH_IDLE);
      CONFIG_VALID[c] = (ch_state[c] == CH_PEND);
    end
  end

  always_comb begin : config_data_pack
    CONFIG_DATA = '0;
    for (int c = 0; c < NCHAN; c++)
      for (int r = 0; r < NREG; r++)
        CONFIG_DATA[(c*NREG+r)*32 +: 32] = data_q[c][r];
  end

  // A committed write is refused while its channel has a command in flight.
  always_comb begin : write_decode
    wmask     = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
    wbits     = w_data & wmask;
    commit    = (w_state == W_IDLE) && aw_held && w_held;
    wr_global = (wr_chan == GLOBAL_CHAN);
    wr_locked = 1'b0;
    for (int c = 0; c < NCHAN; c++)
      if (wr_chan == CW'(c) && busy[c]) wr_locked = 1'b1;
    wr_ok    = in_window(aw_addr) && !wr_locked;
    launch   = '0;
    pend_clr = '0;
    for (int c = 0; c < NCHAN; c++)
      launch[c] = commit && wr_ok && (wr_chan == CW'(c)) && (wr_reg == '0) && (w_strb != 4'b0);
    if (commit && wr_ok && wr_global && wr_reg == NREG_LOG2'(0))
      pend_clr = wbits[NCHAN-1:0];
  end

  always_comb begin : read_mux
    rd_global = (rd_chan == GLOBAL_CHAN);
    rd_ok     = in_window(s_axi.araddr);
    rd_value  = '0;
    if (rd_global) begin
      if (rd_reg == NREG_LOG2'(0))      rd_value = 32'(pend_q);
      else if (rd_reg == NREG_LOG2'(1)) rd_value = 32'(mask_q);
      else if (rd_reg == NREG_LOG2'(2)) rd_value = 32'(busy);
      else if (rd_reg == NREG_LOG2'(3)) rd_value = {VERSION, 8'h00, 8'(NCHAN)};
    end else begin
      for (int c = 0; c < NCHAN; c++)
        if (rd_chan == CW'(c))
          rd_value = (rd_reg == '0) ? cnt_q[c] : data_q[c][rd_reg];
    end
  end

  always_comb begin : fsm_next
    w_next   = w_state;
    r_next   = r_state;
    pend_set = '0;
    case (w_state)
      W_IDLE:  if (commit) w_next = W_RESP;
      W_RESP:  if (s_axi.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (s_axi.arvalid) r_next = R_DATA;
      R_DATA:  if (s_axi.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
    for (int c = 0; c < NCHAN; c++) begin
      ch_next[c] = ch_state[c];
      case (ch_state[c])
        CH_IDLE: if (launch[c]) ch_next[c] = CH_PEND;
        CH_PEND: if (CONFIG_READY[c]) ch_next[c] = CH_RUN;
        CH_RUN: begin
          if (CONFIG_DONE[c]) begin
            ch_next[c]  = CH_IDLE;
            pend_set[c] = 1'b1;
          end
        end
        default: ch_next[c] = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin : fsm_state
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      for (int c = 0; c < NCHAN; c++) ch_state[c] <= CH_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      for (int c = 0; c < NCHAN; c++) ch_state[c] <= ch_next[c];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin : datapath
    if (ARESET) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp_q <= 2'b00;
      rresp_q <= 2'b00;
      rdata_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
        cnt_q[c] <= '0;
        for (int r = 0; r < NREG; r++) data_q[c][r] <= '0;
      end
    end else begin
      if (s_axi.awvalid && s_axi.awready) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi.awaddr;
      end
      if (s_axi.wvalid && s_axi.wready) begin
        w_held <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= wr_ok ? 2'b00 : 2'b10;
      end
      if (s_axi.arvalid && s_axi.arready) begin
        rdata_q <= rd_ok ? rd_value : 32'h0;
        rresp_q <= rd_ok ? 2'b00 : 2'b10;
      end
      for (int c = 0; c < NCHAN; c++) begin
        for (int r = 0; r < NREG; r++)
          if (commit && wr_ok && wr_chan == CW'(c) && wr_reg == NREG_LOG2'(r))
            data_q[c][r] <= (data_q[c][r] & ~wmask) | wbits;
        if (launch[c])
          cnt_q[c] <= '0;
        else if (ch_state[c] != CH_IDLE && cnt_q[c] != 32'hFFFF_FFFF)
          cnt_q[c] <= cnt_q[c] + 32'd1;
      end
      // A completion landing on the same edge as its W1C clear wins.
      pend_q <= (pend_q & ~pend_clr) | pend_set;
      if (commit && wr_ok && wr_global && wr_reg == NREG_LOG2'(1))
        mask_q <= (mask_q & ~wmask[NCHAN-1:0]) | wbits[NCHAN-1:0];
      irq_q <= |(pend_q & mask_q);
    end
  end
endmodule

// File: tb/tb_conf_multi.sv
// tb/tb_conf_multi.sv - scoreboard testbench for conf_multi
module tb_conf_multi;
  localparam int NCHAN = 2;
  localparam int NREG  = 4;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic ACLK = 1'b0;
  logic ARESET = 1'b0;
  logic [NCHAN-1:0] cfg_valid, cfg_ready, cfg_done;
  logic [NCHAN*NREG*32-1:0] cfg_data;
  logic irq;

  conf_multi_if bus ();

  conf_multi #(
    .ADDR_BASE (32'h4000_0000),
    .NCHAN     (NCHAN),
    .NREG_LOG2 (2),
    .VERSION   (16'h0002)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .s_axi        (bus),
    .CONFIG_VALID (cfg_valid),
    .CONFIG_READY (cfg_ready),
    .CONFIG_DONE  (cfg_done),
    .CONFIG_DATA  (cfg_data),
    .CONFIG_IRQ   (irq)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];
  logic [31:0] shadow [NCHAN][NREG];
  logic gap_seen, gap_wready, gap_awready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_data(input string tag, input int c, input int r);
    check(tag, cfg_data[(c*NREG+r)*32 +: 32], shadow[c][r]);
  endtask

  task automatic wait_b(input string tag);
    exp_t e;
    int cyc = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && cyc < 40) begin
      @(negedge ACLK);
      cyc++;
    end
    e = sb.pop_front();
    if (bus.bvalid) check({tag, "_bresp"}, bus.bresp, e.resp);
    else check({tag, "_b_timeout"}, 0, 1);
    @(negedge ACLK);
    bus.bready = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int w_lead, input logic [1:0] exp_resp);
    exp_t e;
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    e.tag = tag; e.data = 32'h0; e.resp = exp_resp;
    sb.push_back(e);
    gap_seen = 1'b0;
    @(negedge ACLK);
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!w_done) begin bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s; end
      if (!aw_done && cyc >= w_lead) begin bus.awvalid = 1'b1; bus.awaddr = a; end
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(negedge ACLK);
      if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_hs) begin w_done = 1; bus.wvalid = 1'b0; end
      if (w_done && !aw_done && !gap_seen) begin
        gap_seen = 1'b1; gap_wready = bus.wready; gap_awready = bus.awready;
      end
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      check({tag, "_addr_timeout"}, 0, 1);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end
    wait_b(tag);
  endtask

  task automatic aw_w_both(input string tag, input logic [31:0] a, input logic [31:0] d);
    @(negedge ACLK);
    bus.awvalid = 1'b1; bus.awaddr = a;
    bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = 4'hF;
    check({tag, "_rdy"}, {bus.awready, bus.wready}, 2'b11);
    @(negedge ACLK);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp);
    exp_t e;
    int cyc = 0;
    e.tag = tag; e.data = exp_data; e.resp = exp_resp;
    sb.push_back(e);
    @(negedge ACLK);
    bus.arvalid = 1'b1; bus.araddr = a;
    while (!bus.arready && cyc < 40) begin @(negedge ACLK); cyc++; end
    @(negedge ACLK);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    cyc = 0;
    while (!bus.rvalid && cyc < 40) begin @(negedge ACLK); cyc++; end
    e = sb.pop_front();
    if (bus.rvalid) begin
      check({tag, "_rdata"}, bus.rdata, e.data);
      check({tag, "_rresp"}, bus.rresp, e.resp);
    end else check({tag, "_r_timeout"}, 0, 1);
    @(negedge ACLK);
    bus.rready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {bus.awready, bus.wready, bus.arready}, 3'b111);
    check({tag, "_valid"}, {bus.bvalid, bus.rvalid, cfg_valid, irq}, 0);
    check({tag, "_resp_rdata"}, {bus.bresp, bus.rresp, bus.rdata}, 0);
    check({tag, "_cfg_data_zero"}, (cfg_data == '0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
    cfg_ready = '0; cfg_done = '0;
    for (int c = 0; c < NCHAN; c++)
      for (int r = 0; r < NREG; r++) shadow[c][r] = 32'h0;

    #1 ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESET = 1'b0;

    // W beat leads AW by two cycles
    wr("w_lead", 32'h4000_0014, 32'hDEAD_BEEF, 4'hF, 2, 2'b00);
    shadow[1][1] = 32'hDEAD_BEEF;
    check("gap_seen", gap_seen, 1);
    check("gap_wready", gap_wready, 0);
    check("gap_awready", gap_awready, 1);
    check_data("c1r1", 1, 1);

    wr("c0r1", 32'h4000_0004, 32'h1234_5678, 4'hF, 0, 2'b00);
    shadow[0][1] = 32'h1234_5678;

    // launch on chan0: READY low 4 cycles, taken on the 5th, DONE 10 cycles later
    fork
      wr("launch0", 32'h4000_0000, 32'h1, 4'hF, 0, 2'b00);
      begin
        int vc = 0, cyc = 0;
        while (!cfg_valid[0] && cyc < 50) begin @(negedge ACLK); cyc++; end
        while (cfg_valid[0] && vc < 20) begin
          vc++;
          cfg_ready[0] = (vc == 5);
          @(negedge ACLK);
        end
        cfg_ready[0] = 1'b0;
        check("valid0_cycles", vc, 5);
        repeat (9) @(negedge ACLK);
        cfg_done[0] = 1'b1;
        @(negedge ACLK);
        cfg_done[0] = 1'b0;
      end
    join
    shadow[0][0] = 32'h1;
    repeat (2) @(negedge ACLK);
    rd("cnt0", 32'h4000_0000, 32'd15, 2'b00);
    rd("pend_01", 32'h4000_0020, 32'h1, 2'b00);
    check("irq_masked", irq, 0);
    check_data("c0r0", 0, 0);

    wr("pend_clr0", 32'h4000_0020, 32'h1, 4'hF, 0, 2'b00);
    wr("mask3", 32'h4000_0024, 32'h3, 4'hF, 0, 2'b00);
    rd("mask_rd", 32'h4000_0024, 32'h3, 2'b00);
    check("irq_after_mask", irq, 0);

    cfg_ready[1] = 1'b1;
    fork
      wr("launch1", 32'h4000_0010, 32'h1, 4'hF, 0, 2'b00);
      begin
        int cyc = 0;
        while (!cfg_valid[1] && cyc < 50) begin @(negedge ACLK); cyc++; end
        repeat (3) @(negedge ACLK);
        cfg_done[1] = 1'b1;
        @(negedge ACLK);
        cfg_done[1] = 1'b0;
        check("irq_same_cycle", irq, 0);
        @(negedge ACLK);
        check("irq_after_done", irq, 1);
      end
    join
    shadow[1][0] = 32'h1;
    wr("pend_w1c2", 32'h4000_0020, 32'h2, 4'hF, 0, 2'b00);
    @(negedge ACLK);
    check("irq_cleared", irq, 0);

    // chan1 DONE on the same edge as the W1C of its PEND bit
    wr("launch1b", 32'h4000_0010, 32'h3, 4'hF, 0, 2'b00);
    shadow[1][0] = 32'h3;
    begin
      exp_t e;
      e.tag = "w1c_race"; e.data = 0; e.resp = 2'b00;
      sb.push_back(e);
      aw_w_both("w1c_race", 32'h4000_0020, 32'h2);
      cfg_done[1] = 1'b1;
      @(negedge ACLK);
      cfg_done[1] = 1'b0;
      wait_b("w1c_race");
    end
    rd("pend_race", 32'h4000_0020, 32'h2, 2'b00);
    wr("pend_clr1", 32'h4000_0020, 32'h2, 4'hF, 0, 2'b00);
    rd("pend_zero", 32'h4000_0020, 32'h0, 2'b00);

    // write lock while chan0 runs
    cfg_ready[0] = 1'b1;
    wr("launch0b", 32'h4000_0000, 32'h1, 4'hF, 0, 2'b00);
    cfg_ready[0] = 1'b0;
    rd("busy0", 32'h4000_0028, 32'h1, 2'b00);
    wr("locked", 32'h4000_0004, 32'hFFFF_0000, 4'hF, 0, 2'b10);
    check_data("c0r1_locked", 0, 1);
    @(negedge ACLK);
    cfg_done[0] = 1'b1;
    @(negedge ACLK);
    cfg_done[0] = 1'b0;
    rd("busy_none", 32'h4000_0028, 32'h0, 2'b00);

    wr("bad_chan", 32'h4000_0030, 32'h5, 4'hF, 0, 2'b10);
    wr("bad_base", 32'h5000_0000, 32'h5, 4'hF, 0, 2'b10);
    rd("rd_bad_chan", 32'h4000_0030, 32'h0, 2'b10);
    rd("rd_bad_base", 32'h5000_0000, 32'h0, 2'b10);
    check_data("c0r0_after_bad", 0, 0);
    rd("id", 32'h4000_002C, 32'h0002_0002, 2'b00);

    wr("byte_full", 32'h4000_0008, 32'h1111_1111, 4'hF, 0, 2'b00);
    wr("byte_one", 32'h4000_0008, 32'h0000_AB00, 4'b0010, 0, 2'b00);
    shadow[0][2] = 32'h1111_AB11;
    check_data("c0r2_byte", 0, 2);
    rd("rd_byte", 32'h4000_0008, 32'h1111_AB11, 2'b00);

    wr("strb0", 32'h4000_0000, 32'h1, 4'h0, 0, 2'b00);
    check("strb0_no_launch", cfg_valid, 0);
    rd("busy_strb0", 32'h4000_0028, 32'h0, 2'b00);

    // reset with BVALID and VALID[0] both high
    wr("launch0c", 32'h4000_0000, 32'h1, 4'hF, 0, 2'b00);
    aw_w_both("pre_rst", 32'h4000_0014, 32'h7777_7777);
    begin
      int cyc = 0;
      while (!bus.bvalid && cyc < 40) begin @(negedge ACLK); cyc++; end
    end
    check("pre_rst_state", {bus.bvalid, cfg_valid[0], irq}, 3'b111);
    #2 ARESET = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge ACLK);
    ARESET = 1'b0;
    for (int c = 0; c < NCHAN; c++)
      for (int r = 0; r < NREG; r++) shadow[c][r] = 32'h0;
    wr("post_rst", 32'h4000_0018, 32'h5555_AAAA, 4'hF, 0, 2'b00);
    shadow[1][2] = 32'h5555_AAAA;
    check_data("c1r2_post", 1, 2);
    check_data("c1r1_post", 1, 1);
    rd("pend_post", 32'h4000_0020, 32'h0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
